// File: rtl/mdu_hilo_pkg.sv
// mdu_hilo_pkg: opcodes, default latencies and FSM state type for the multiply/divide unit
package mdu_hilo_pkg;

    localparam logic [3:0] MDU_NOP   = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } mdu_state_e;

    function automatic logic mdu_is_mult(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic mdu_is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_hilo_arith.sv
// mdu_hilo_arith: combinational signed/unsigned product and truncating quotient/remainder
module mdu_hilo_arith #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic               signed_i,
    output logic [2*WIDTH-1:0] prod_o,
    output logic [WIDTH-1:0]   quot_o,
    output logic [WIDTH-1:0]   rem_o,
    output logic               div_zero_o
);

    logic [2*WIDTH-1:0] a_ext, b_ext;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag;

    // One 2W-bit multiplier serves both signednesses via sign/zero extension; division works on magnitudes,
    // so INT_MIN / -1 wraps naturally to INT_MIN with a zero remainder.
    always_comb begin
        a_ext      = {{WIDTH{signed_i & a_i[WIDTH-1]}}, a_i};
        b_ext      = {{WIDTH{signed_i & b_i[WIDTH-1]}}, b_i};
        prod_o     = a_ext * b_ext;
        a_neg      = signed_i & a_i[WIDTH-1];
        b_neg      = signed_i & b_i[WIDTH-1];
        a_mag      = a_neg ? -a_i : a_i;
        b_mag      = b_neg ? -b_i : b_i;
        div_zero_o = (b_i == '0);
        q_mag      = div_zero_o ? '0 : a_mag / b_mag;
        r_mag      = div_zero_o ? '0 : a_mag % b_mag;
        quot_o     = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem_o      = a_neg ? -r_mag : r_mag;
    end

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit with architectural HI/LO, busy stall and flush
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] MDU_i_Operand1,
    input  logic [WIDTH-1:0] MDU_i_Operand2,
    input  logic [3:0]       MDU_i_Operation,
    input  logic             MDU_i_Start,
    input  logic             MDU_i_Flush,
    output logic             MDU_o_Busy,
    output logic [WIDTH-1:0] MDU_o_HI,
    output logic [WIDTH-1:0] MDU_o_LO,
    output logic [WIDTH-1:0] MDU_o_Result,
    output logic             MDU_o_DivZero
);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] stage_q, stage_d;
    logic               stage_zero_q, stage_zero_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               dz_q, dz_d;
    logic               accept, is_signed, div_zero;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot, rem;

    assign is_signed = (MDU_i_Operation == MDU_MULT) || (MDU_i_Operation == MDU_DIV);
    assign accept    = MDU_i_Start && !MDU_i_Flush && (state_q == ST_IDLE);

    mdu_hilo_arith #(.WIDTH(WIDTH)) u_arith (
        .a_i        (MDU_i_Operand1),
        .b_i        (MDU_i_Operand2),
        .signed_i   (is_signed),
        .prod_o     (prod),
        .quot_o     (quot),
        .rem_o      (rem),
        .div_zero_o (div_zero)
    );

    // Next state: results are staged at accept and only reach HI/LO when the countdown expires unflushed.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        stage_d      = stage_q;
        stage_zero_d = stage_zero_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        dz_d         = dz_q;
        if (state_q == ST_RUN) begin
            if (MDU_i_Flush) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (cnt_q == CNT_W'(1)) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                if (stage_zero_q) dz_d = 1'b1;
                else {hi_d, lo_d} = stage_q;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end else if (accept) begin
            if (mdu_is_mult(MDU_i_Operation)) begin
                state_d      = ST_RUN;
                cnt_d        = CNT_W'(MULT_CYCLES);
                stage_d      = prod;
                stage_zero_d = 1'b0;
            end else if (mdu_is_div(MDU_i_Operation)) begin
                state_d      = ST_RUN;
                cnt_d        = CNT_W'(DIV_CYCLES);
                stage_d      = {rem, quot};
                stage_zero_d = div_zero;
                if (!div_zero) dz_d = 1'b0;
            end else if (MDU_i_Operation == MDU_MTHI) begin
                hi_d = MDU_i_Operand1;
            end else if (MDU_i_Operation == MDU_MTLO) begin
                lo_d = MDU_i_Operand1;
            end
        end
    end

    // State, counter, staging and architectural registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            stage_q      <= '0;
            stage_zero_q <= 1'b0;
            hi_q         <= '0;
            lo_q         <= '0;
            dz_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            stage_q      <= stage_d;
            stage_zero_q <= stage_zero_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            dz_q         <= dz_d;
        end
    end

    // Move-from read port straight off the current HI/LO registers.
    always_comb begin
        MDU_o_Result = (MDU_i_Operation == MDU_MFHI) ? hi_q :
                       (MDU_i_Operation == MDU_MFLO) ? lo_q : '0;
    end

    assign MDU_o_Busy    = (state_q == ST_RUN);
    assign MDU_o_HI      = hi_q;
    assign MDU_o_LO      = lo_q;
    assign MDU_o_DivZero = dz_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: randomized scoreboard bench for mdu_hilo against an arithmetic reference model
module tb_mdu_hilo;
    import mdu_hilo_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] op1 = '0, op2 = '0;
    logic [3:0]  opr = MDU_NOP;
    logic        start = 1'b0, flush = 1'b0;
    logic        busy, dz;
    logic [31:0] hi, lo, res;

    mdu_hilo dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .MDU_i_Operand1  (op1),
        .MDU_i_Operand2  (op2),
        .MDU_i_Operation (opr),
        .MDU_i_Start     (start),
        .MDU_i_Flush     (flush),
        .MDU_o_Busy      (busy),
        .MDU_o_HI        (hi),
        .MDU_o_LO        (lo),
        .MDU_o_Result    (res),
        .MDU_o_DivZero   (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          len;
        string       tag;
    } cexp_t;

    typedef struct {
        logic [31:0] r;
        logic        chk_busy;
        string       tag;
    } rexp_t;

    cexp_t       cq[$];
    rexp_t       rq[$];
    cexp_t       c_m;
    rexp_t       r_m;
    int          nvec = 0, nerr = 0, run = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic        m_dz = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // Monitor: read results checked whenever Start is presented; commit entries popped when Busy falls.
    always @(negedge clk) begin
        if (start) begin
            if (rq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL rd_queue: start seen with no expectation");
            end else begin
                r_m = rq.pop_front();
                check({r_m.tag, " result"}, 64'(res), 64'(r_m.r));
                if (r_m.chk_busy) check({r_m.tag, " busy"}, 64'(busy), 64'(0));
            end
        end
        if (busy) run++;
        else if (run > 0) begin
            if (cq.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL commit_queue: busy fell with no expectation");
            end else begin
                c_m = cq.pop_front();
                check({c_m.tag, " HI"}, 64'(hi), 64'(c_m.hi));
                check({c_m.tag, " LO"}, 64'(lo), 64'(c_m.lo));
                check({c_m.tag, " DivZero"}, 64'(dz), 64'(c_m.dz));
                if (c_m.len >= 0) check({c_m.tag, " busy_cycles"}, 64'(run), 64'(c_m.len));
            end
            run = 0;
        end
    end

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        rexp_t r;
        @(posedge clk);
        #1;
        start = 1'b1;
        opr   = op;
        op1   = a;
        op2   = b;
        r.r        = (op == MDU_MFHI) ? m_hi : (op == MDU_MFLO) ? m_lo : 32'h0;
        r.chk_busy = (op == MDU_MFHI) || (op == MDU_MFLO);
        r.tag      = $sformatf("op%0d", op);
        rq.push_back(r);
        @(posedge clk);
        #1;
        start = 1'b0;
        opr   = MDU_NOP;
    endtask

    task automatic exec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        cexp_t       e;
        logic [63:0] p;
        longint      sa, sb, q, r;
        drive(op, a, b);
        if (op == MDU_MULT || op == MDU_MULTU) begin
            p = (op == MDU_MULT) ? 64'(longint'($signed(a)) * longint'($signed(b)))
                                 : {32'h0, a} * {32'h0, b};
            m_hi = p[63:32];
            m_lo = p[31:0];
            e = cexp_t'{m_hi, m_lo, m_dz, MDU_MULT_CYCLES_DEF, $sformatf("mul%0d %h*%h", op, a, b)};
            cq.push_back(e);
        end else if (op == MDU_DIV || op == MDU_DIVU) begin
            if (b == 0) m_dz = 1'b1;
            else begin
                sa = (op == MDU_DIV) ? longint'($signed(a)) : longint'({32'h0, a});
                sb = (op == MDU_DIV) ? longint'($signed(b)) : longint'({32'h0, b});
                q  = sa / sb;
                r  = sa % sb;
                m_lo = 32'(q);
                m_hi = 32'(r);
                m_dz = 1'b0;
            end
            e = cexp_t'{m_hi, m_lo, m_dz, MDU_DIV_CYCLES_DEF, $sformatf("div%0d %h/%h", op, a, b)};
            cq.push_back(e);
        end else if (op == MDU_MTHI) m_hi = a;
        else if (op == MDU_MTLO) m_lo = a;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (i == 40) begin
            nvec++;
            nerr++;
            $display("FAIL wait_idle: busy=%b after 40 cycles, required 0", busy);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  ops[8];
        logic [3:0]  op;
        logic [31:0] a, b;
        int          k, sel;
        ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_MFHI, MDU_MFLO};
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset HI", 64'(hi), 64'(0));
        check("reset LO", 64'(lo), 64'(0));
        check("reset DivZero", 64'(dz), 64'(0));

        exec(MDU_MULT, 32'hFFFFFFFF, 32'h2);          wait_idle();
        exec(MDU_MULTU, 32'hFFFFFFFF, 32'h2);         wait_idle();
        exec(MDU_DIV, 32'hFFFFFFF9, 32'h2);           wait_idle();
        exec(MDU_DIVU, 32'h7, 32'h2);                 wait_idle();
        exec(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);    wait_idle();

        exec(MDU_DIV, 32'h5, 32'h0);
        drive(MDU_MTLO, 32'hDEADBEEF, 32'h0);
        wait_idle();
        exec(MDU_MFLO, 32'h0, 32'h0);

        exec(MDU_MTHI, 32'h12345678, 32'h0);
        exec(MDU_MFHI, 32'h0, 32'h0);

        flush = 1'b1;
        drive(MDU_MTHI, 32'hA5A5A5A5, 32'h0);
        flush = 1'b0;
        exec(MDU_MFHI, 32'h0, 32'h0);

        drive(MDU_MULT, 32'h3, 32'h4);
        cq.push_back(cexp_t'{m_hi, m_lo, m_dz, 3, "flushed mult"});
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_idle();
        exec(MDU_MFLO, 32'h0, 32'h0);

        drive(MDU_DIV, 32'h9, 32'h0);
        cq.push_back(cexp_t'{32'h0, 32'h0, 1'b0, -1, "reset mid-run"});
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        m_dz = 1'b0;
        wait_idle();
        exec(MDU_MULT, 32'h2, 32'h3);                 wait_idle();

        for (int n = 0; n < 80; n++) begin
            a   = $urandom;
            b   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'h0;
            if (sel == 1) begin
                a = 32'h80000000;
                b = 32'hFFFFFFFF;
            end
            if (sel == 2) b = 32'($urandom_range(1, 15));
            if (sel == 3) a = 32'h0 - 32'($urandom_range(1, 100));
            k = $urandom_range(0, 11);
            op = (k < 8) ? ops[k] : (k == 8) ? MDU_NOP : 4'($urandom_range(9, 15));
            exec(op, a, b);
            if (mdu_is_mult(op) || mdu_is_div(op)) wait_idle();
        end
        exec(MDU_MFHI, 32'h0, 32'h0);
        exec(MDU_MFLO, 32'h0, 32'h0);

        repeat (2) @(negedge clk);
        check("commit queue drained", 64'(cq.size()), 64'(0));
        check("read queue drained", 64'(rq.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
